// File: rtl/axis_len_pkg.sv
// Shared definitions for the length-to-tkeep framer: default widths, FSM encoding
// and width helpers for parameterised instances.
package axis_len_pkg;

  localparam int unsigned TKEEP_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH      = 8 * TKEEP_WIDTH_DEF;
  // Enough bits to hold 0..TKEEP_WIDTH bytes left in a single beat.
  localparam int unsigned REM_WIDTH       = $clog2(TKEEP_WIDTH_DEF + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned data_width(input int unsigned keep_width);
    return 8 * keep_width;
  endfunction

  function automatic int unsigned rem_width(input int unsigned keep_width);
    return $clog2(keep_width + 1);
  endfunction

endpackage

// File: rtl/len_to_tkeep.sv
// Remaining byte count -> contiguous low-order tkeep mask plus last-beat flag.
module len_to_tkeep
  import axis_len_pkg::*;
#(
  parameter int unsigned TKEEP_WIDTH = TKEEP_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic [LEN_WIDTH-1:0]   remaining,
  output logic [TKEEP_WIDTH-1:0] tkeep,
  output logic                   last
);

  localparam int unsigned RW = rem_width(TKEEP_WIDTH);

  logic [RW-1:0] rem_clamped;

  always_comb begin
    tkeep       = '0;
    rem_clamped = (remaining >= LEN_WIDTH'(TKEEP_WIDTH)) ? RW'(TKEEP_WIDTH) : RW'(remaining);
    last        = (remaining <= LEN_WIDTH'(TKEEP_WIDTH));
    for (int i = 0; i < TKEEP_WIDTH; i++) begin
      tkeep[i] = (rem_clamped > RW'(i));
    end
  end

endmodule

// File: rtl/len_to_tkeep_framer.sv
// Frames an unframed beat stream into AXI-Stream packets from a byte-length command,
// generating tkeep/tlast through a single registered output stage.
module len_to_tkeep_framer
  import axis_len_pkg::*;
#(
  parameter int unsigned TKEEP_WIDTH = TKEEP_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [8*TKEEP_WIDTH-1:0] s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [8*TKEEP_WIDTH-1:0] m_tdata,
  output logic [TKEEP_WIDTH-1:0]   m_tkeep,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     busy
);

  localparam int unsigned DW = data_width(TKEEP_WIDTH);

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic [TKEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;

  logic [TKEEP_WIDTH-1:0] beat_keep;
  logic                   beat_last;
  logic                   cmd_fire, s_fire;

  len_to_tkeep #(
    .TKEEP_WIDTH (TKEEP_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH)
  ) u_len_to_tkeep (
    .remaining (rem_q),
    .tkeep     (beat_keep),
    .last      (beat_last)
  );

  // Gated by rst so the command port reads not-ready while reset is held.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign s_tready  = (state_q == RUN) && (!tvalid_q || m_tready);
  assign busy      = (state_q == RUN);

  assign cmd_fire = cmd_valid && cmd_ready;
  assign s_fire   = s_tvalid && s_tready;

  assign m_tdata  = tdata_q;
  assign m_tkeep  = tkeep_q;
  assign m_tlast  = tlast_q;
  assign m_tvalid = tvalid_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire && (cmd_len != '0)) begin
          rem_d   = cmd_len;
          state_d = RUN;
        end
      end
      RUN: begin
        if (s_fire) begin
          rem_d = (rem_q > LEN_WIDTH'(TKEEP_WIDTH)) ? rem_q - LEN_WIDTH'(TKEEP_WIDTH) : '0;
          if (beat_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (s_fire) begin
      tdata_d  = s_tdata;
      tkeep_d  = beat_keep;
      tlast_d  = beat_last;
      tvalid_d = 1'b1;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_len_to_tkeep_framer.sv
// Directed bench for len_to_tkeep_framer with an expected-beat scoreboard and stall checks.
module tb_len_to_tkeep_framer;

  localparam int unsigned KW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned DW = 8 * KW;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    rand_ready = 1'b0;

  len_to_tkeep_framer #(
    .TKEEP_WIDTH (KW),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_len   (cmd_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink backpressure: always ready, or a coin flip per cycle during stall tests.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: decide at the falling edge what the next rising edge will transfer.
  initial begin
    bit    stall_prev;
    beat_t held;
    beat_t b;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_tvalid", 64'(m_tvalid), 64'(1));
          check("stall_tdata", 64'(m_tdata), 64'(held.data));
          check("stall_tkeep", 64'(m_tkeep), 64'(held.keep));
          check("stall_tlast", 64'(m_tlast), 64'(held.last));
        end
        stall_prev = m_tvalid && !m_tready;
        held       = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(exp_q.size()), 64'(1));
          end else begin
            b = exp_q.pop_front();
            check("m_tdata", 64'(m_tdata), 64'(b.data));
            check("m_tkeep", 64'(m_tkeep), 64'(b.keep));
            check("m_tlast", 64'(m_tlast), 64'(b.last));
          end
        end
      end
    end
  end

  task automatic send_cmd(input int len);
    bit ok;
    int n;
    ok        = 1'b0;
    n         = 0;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_handshake", 64'(ok), 64'(1));
  endtask

  // Drives up to max_beats beats of a len-byte packet; expectations come from a byte count model.
  task automatic send_beats(input int len, input int max_beats);
    int    nb;
    int    rem;
    bit    ok;
    int    n;
    beat_t e;
    nb = (len + KW - 1) / KW;
    for (int i = 0; i < nb && i < max_beats; i++) begin
      rem      = len - i * KW;
      s_tdata  = {$urandom, $urandom};
      s_tvalid = 1'b1;
      ok       = 1'b0;
      n        = 0;
      while (!ok && n < 200) begin
        @(negedge clk);
        ok = s_tready;
        if (ok) begin
          e.data = s_tdata;
          e.keep = '0;
          for (int j = 0; j < KW; j++) e.keep[j] = (j < rem);
          e.last = (rem <= KW);
          exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        n++;
      end
      check("beat_handshake", 64'(ok), 64'(1));
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    check("rst_m_tlast", 64'(m_tlast), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Single full beat, then the command port reopens.
    send_cmd(8);
    check("run_busy", 64'(busy), 64'(1));
    check("run_cmd_ready", 64'(cmd_ready), 64'(0));
    send_beats(8, 99);
    check("len8_s_tready_after_last", 64'(s_tready), 64'(0));
    check("len8_cmd_ready_1", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    check("len8_cmd_ready_2", 64'(cmd_ready), 64'(1));
    wait_drain();

    // Partial last beat.
    send_cmd(13);
    send_beats(13, 99);
    wait_drain();

    // Zero-length command is swallowed; then a one-byte packet.
    send_cmd(0);
    check("len0_busy", 64'(busy), 64'(0));
    check("len0_cmd_ready", 64'(cmd_ready), 64'(1));
    send_cmd(1);
    send_beats(1, 99);
    wait_drain();

    // Random backpressure across a three-beat packet.
    rand_ready = 1'b1;
    send_cmd(24);
    send_beats(24, 99);
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-packet, right after the first beat is accepted.
    send_cmd(20);
    send_beats(20, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_s_tready", 64'(s_tready), 64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("midrst_m_tlast", 64'(m_tlast), 64'(0));
    exp_q.delete();
    s_tvalid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("after_rst_s_tready", 64'(s_tready), 64'(0));
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    send_cmd(4);
    send_beats(4, 99);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/len_to_tkeep_framer.md
LEN_TO_TKEEP_FRAMER -- requirements
Module: len_to_tkeep_framer

Interface
REQ-001 The block SHALL have parameter TKEEP_WIDTH, default 8: bytes per beat; data width is 8*TKEEP_WIDTH.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16: width of the byte-length command.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port cmd_len, input, LEN_WIDTH bits: packet length in bytes.
REQ-006 The block SHALL have ports cmd_valid (input, 1 bit) and cmd_ready (output, 1 bit): command handshake.
REQ-007 The block SHALL have ports s_tdata (input, 8*TKEEP_WIDTH bits), s_tvalid (input, 1 bit) and s_tready (output, 1 bit): unframed input data stream.
REQ-008 The block SHALL have ports m_tdata (output, 8*TKEEP_WIDTH), m_tkeep (output, TKEEP_WIDTH), m_tlast (output, 1), m_tvalid (output, 1) and m_tready (input, 1): framed AXI-Stream output.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a packet is in progress.

Function
REQ-010 A transfer SHALL occur on any channel only in a cycle where valid and ready are both high at the clk rising edge.
REQ-011 The FSM SHALL have exactly two states, IDLE and RUN; cmd_ready=1 only in IDLE; busy=1 only in RUN.
REQ-012 In IDLE, a command transfer with cmd_len!=0 SHALL load the remaining-bytes counter (LEN_WIDTH bits) with cmd_len and enter RUN on the next cycle.
REQ-013 In IDLE, a command transfer with cmd_len==0 SHALL be consumed, emit no beat, and leave the FSM in IDLE.
REQ-014 s_tready SHALL be (state==RUN) && (!m_tvalid || m_tready); s_tready is 0 in IDLE.
REQ-015 The output SHALL be one register stage: an input beat accepted in cycle N appears on m_* in cycle N+1; with m_tready held high, throughput is one beat per cycle.
REQ-016 m_tdata SHALL equal the accepted s_tdata unmodified; bytes beyond m_tkeep are passed through and are not zeroed.
REQ-017 m_tkeep SHALL be all ones when remaining>=TKEEP_WIDTH; otherwise it SHALL be (1<<remaining)-1, i.e. contiguous ones from bit 0 (byte 0 is first on the wire).
REQ-018 m_tlast SHALL be 1 iff remaining<=TKEEP_WIDTH at the time the beat is accepted.
REQ-019 Each accepted input beat SHALL decrement remaining by TKEEP_WIDTH, saturating at 0.
REQ-020 Accepting the tlast beat SHALL return the FSM to IDLE in the next cycle; s_tready SHALL be 0 in that next cycle.
REQ-021 The next command SHALL NOT be accepted in the cycle the last beat is accepted, so there is a one-cycle gap before the next command.
REQ-022 While m_tvalid=1 and m_tready=0, m_tdata, m_tkeep and m_tlast SHALL hold stable and m_tvalid SHALL stay high.
REQ-023 m_tvalid SHALL clear after the output beat transfers, unless a new beat is loaded in the same cycle.
REQ-024 The maximum legal cmd_len is 2^LEN_WIDTH-1; no length is rejected.

Reset
REQ-025 Assertion of rst SHALL immediately, without waiting for clk, force state=IDLE, remaining=0 and m_tvalid=0.
REQ-026 While rst is asserted, cmd_ready, s_tready and busy SHALL read 0; m_tkeep and m_tlast SHALL read 0.
REQ-027 A reset asserted mid-packet SHALL discard the rest of the packet; no tlast is emitted for it.
REQ-028 After rst deasserts, cmd_ready SHALL be 1 from the first clk edge.

Structure
REQ-029 The localparams for data width and beat-remainder width SHALL live in the shared package/header axis_len_pkg, together with the state encoding IDLE=0 and RUN=1.
REQ-030 The length-to-mask logic SHALL be one combinational sub-module, len_to_tkeep (remaining bytes -> TKEEP_WIDTH mask plus last flag), instantiated once.

Verification
REQ-031 The bench SHALL cover, with TKEEP_WIDTH=8 and m_tready=1: cmd_len=8 -> exactly one beat, tkeep=0xFF, tlast=1, then cmd_ready=1 two cycles after that beat is accepted.
REQ-032 The bench SHALL cover cmd_len=13 -> two beats, (0xFF, tlast=0) then (0x1F, tlast=1), with data in input order.
REQ-033 The bench SHALL cover cmd_len=0 then cmd_len=1 -> no beat for the first command, then one beat with tkeep=0x01 and tlast=1.
REQ-034 The bench SHALL cover cmd_len=24 with m_tready toggling randomly -> three beats with tkeep=0xFF and tlast only on the third, and m_* stable during every stall.
REQ-035 The bench SHALL cover cmd_len=20 with rst pulsed after the first beat -> m_tvalid=0 asynchronously, no further beats, and after release cmd_len=4 yields one beat with tkeep=0x0F and tlast=1.
